// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: geometry, opcode encoding, opcode classes
// and the per-cycle retirement decision record.
package reorder_buffer_pkg;

    localparam int ROB_SIZE    = 64;
    localparam int IDX_W       = 6;
    localparam int FULL_MARGIN = 2;

    typedef logic [IDX_W-1:0] rob_idx_t;
    typedef logic [IDX_W:0]   rob_cnt_t;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_ADD
    } opcode_t;

    typedef struct packed {
        logic        fire;
        logic        rf_write;
        logic        store;
        logic        flush;
        logic [31:0] redirect;
    } commit_dec_t;

    function automatic logic is_branch(input opcode_t op);
        return op inside {[OP_BEQ:OP_BGEU]};
    endfunction

    function automatic logic is_store(input opcode_t op);
        return op inside {[OP_SB:OP_SW]};
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / lookup / CDB / retirement bundle between the issue stage and the ROB.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_jumped;
    opcode_t     issue_opcode;
    logic [31:0] issue_pc;

    rob_idx_t    check1;
    rob_idx_t    check2;
    logic        value_valid1;
    logic        value_valid2;
    logic [31:0] value1;
    logic [31:0] value2;

    logic        cdb_valid;
    rob_idx_t    cdb_index;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;

    logic        commit_valid;
    logic [4:0]  commit_rd;
    rob_idx_t    commit_index;
    logic [31:0] commit_value;
    logic        store_commit;
    rob_idx_t    store_index;
    logic        flush;
    logic [31:0] flush_pc;
    logic        full;

    modport master (
        output issue_valid, issue_rd, issue_jumped, issue_opcode, issue_pc,
        output check1, check2,
        output cdb_valid, cdb_index, cdb_value, cdb_taken, cdb_target,
        input  value_valid1, value_valid2, value1, value2,
        input  commit_valid, commit_rd, commit_index, commit_value,
        input  store_commit, store_index, flush, flush_pc, full
    );

    modport slave (
        input  issue_valid, issue_rd, issue_jumped, issue_opcode, issue_pc,
        input  check1, check2,
        input  cdb_valid, cdb_index, cdb_value, cdb_taken, cdb_target,
        output value_valid1, value_valid2, value1, value2,
        output commit_valid, commit_rd, commit_index, commit_value,
        output store_commit, store_index, flush, flush_pc, full
    );

endinterface

// File: rtl/reorder_buffer_commit_unit.sv
// Classifies the head entry and decides what its retirement does this cycle:
// register write, store release, and/or a pipeline redirect.
module reorder_buffer_commit_unit
    import reorder_buffer_pkg::*;
(
    input  logic        head_ok,
    input  logic [4:0]  head_rd,
    input  opcode_t     head_opcode,
    input  logic        head_jumped,
    input  logic        head_taken,
    input  logic [31:0] head_pc,
    input  logic [31:0] head_target,
    output commit_dec_t dec
);

    always_comb begin
        dec = '0;
        if (head_ok) begin
            dec.fire = 1'b1;
            if (is_store(head_opcode)) begin
                dec.store = 1'b1;
            end else if (is_branch(head_opcode)) begin
                // Only a wrong prediction redirects; fall-through resumes at pc+4.
                if (head_taken != head_jumped) begin
                    dec.flush    = 1'b1;
                    dec.redirect = head_taken ? head_target : head_pc + 32'd4;
                end
            end else begin
                dec.rf_write = (head_rd != 5'd0);
                // JALR target is never predicted, so it always redirects.
                if (head_opcode == OP_JALR) begin
                    dec.flush    = 1'b1;
                    dec.redirect = head_target;
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, captures CDB results,
// serves operand lookups, retires one entry per cycle from head.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    reorder_buffer_if.slave bus
);

    logic [4:0]  rd_mem     [ROB_SIZE];
    opcode_t     op_mem     [ROB_SIZE];
    logic        jumped_mem [ROB_SIZE];
    logic [31:0] pc_mem     [ROB_SIZE];
    logic [31:0] value_mem  [ROB_SIZE];
    logic        taken_mem  [ROB_SIZE];
    logic [31:0] target_mem [ROB_SIZE];

    logic [ROB_SIZE-1:0] ready_reg;
    rob_idx_t            head_reg;
    rob_idx_t            tail_reg;
    rob_cnt_t            count_reg;

    logic        commit_valid_reg;
    logic [4:0]  commit_rd_reg;
    rob_idx_t    commit_index_reg;
    logic [31:0] commit_value_reg;
    logic        store_commit_reg;
    rob_idx_t    store_index_reg;
    logic        flush_reg;
    logic [31:0] flush_pc_reg;

    logic        issue_en;
    logic        cdb_en;
    logic        head_ok;
    commit_dec_t dec;

    // During the flush cycle the front end is being redirected, so its traffic is stale.
    assign issue_en = rdy && !flush_reg && bus.issue_valid;
    assign cdb_en   = rdy && !flush_reg && bus.cdb_valid;
    assign head_ok  = (count_reg != '0) && ready_reg[head_reg] && !flush_reg;

    always_ff @(posedge clk) begin
        if (issue_en) begin
            rd_mem[tail_reg]     <= bus.issue_rd;
            op_mem[tail_reg]     <= bus.issue_opcode;
            jumped_mem[tail_reg] <= bus.issue_jumped;
            pc_mem[tail_reg]     <= bus.issue_pc;
        end
        if (cdb_en) begin
            value_mem[bus.cdb_index]  <= bus.cdb_value;
            taken_mem[bus.cdb_index]  <= bus.cdb_taken;
            target_mem[bus.cdb_index] <= bus.cdb_target;
        end
    end

    // Ready bits are not cleared at retirement: a retired result stays readable
    // until its slot is reallocated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= '0;
        end else if (rdy) begin
            if (flush_reg) begin
                ready_reg <= '0;
            end else begin
                if (issue_en) ready_reg[tail_reg] <= 1'b0;
                if (cdb_en)   ready_reg[bus.cdb_index] <= 1'b1;
            end
        end
    end

    reorder_buffer_commit_unit u_commit (
        .head_ok     (head_ok),
        .head_rd     (rd_mem[head_reg]),
        .head_opcode (op_mem[head_reg]),
        .head_jumped (jumped_mem[head_reg]),
        .head_taken  (taken_mem[head_reg]),
        .head_pc     (pc_mem[head_reg]),
        .head_target (target_mem[head_reg]),
        .dec         (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            commit_valid_reg <= 1'b0;
            commit_rd_reg    <= '0;
            commit_index_reg <= '0;
            commit_value_reg <= '0;
            store_commit_reg <= 1'b0;
            store_index_reg  <= '0;
            flush_reg        <= 1'b0;
            flush_pc_reg     <= '0;
        end else if (rdy) begin
            if (flush_reg) begin
                // Issuer resets its tag counter in this same cycle, so tags realign at 0.
                head_reg         <= '0;
                tail_reg         <= '0;
                count_reg        <= '0;
                commit_valid_reg <= 1'b0;
                store_commit_reg <= 1'b0;
                flush_reg        <= 1'b0;
            end else begin
                if (issue_en) tail_reg <= tail_reg + rob_idx_t'(1);
                if (dec.fire) head_reg <= head_reg + rob_idx_t'(1);
                count_reg <= count_reg + rob_cnt_t'(issue_en) - rob_cnt_t'(dec.fire);

                commit_valid_reg <= dec.rf_write;
                if (dec.rf_write) begin
                    commit_rd_reg    <= rd_mem[head_reg];
                    commit_index_reg <= head_reg;
                    commit_value_reg <= value_mem[head_reg];
                end
                store_commit_reg <= dec.store;
                if (dec.store) store_index_reg <= head_reg;
                flush_reg <= dec.flush;
                if (dec.flush) flush_pc_reg <= dec.redirect;
            end
        end
    end

    // Two lookup ports; a result on the CDB this cycle beats the stored copy.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
        rob_idx_t    idx;
        logic        valid;
        logic [31:0] value;

        assign idx = (gi == 0) ? bus.check1 : bus.check2;

        always_comb begin
            valid = 1'b0;
            value = '0;
            if (bus.cdb_valid && bus.cdb_index == idx) begin
                valid = 1'b1;
                value = bus.cdb_value;
            end else if (ready_reg[idx]) begin
                valid = 1'b1;
                value = value_mem[idx];
            end
        end
    end

    assign bus.value_valid1 = g_lookup[0].valid;
    assign bus.value1       = g_lookup[0].value;
    assign bus.value_valid2 = g_lookup[1].valid;
    assign bus.value2       = g_lookup[1].value;

    assign bus.commit_valid = commit_valid_reg;
    assign bus.commit_rd    = commit_rd_reg;
    assign bus.commit_index = commit_index_reg;
    assign bus.commit_value = commit_value_reg;
    assign bus.store_commit = store_commit_reg;
    assign bus.store_index  = store_index_reg;
    assign bus.flush        = flush_reg;
    assign bus.flush_pc     = flush_pc_reg;
    assign bus.full         = (count_reg + rob_cnt_t'(FULL_MARGIN)) >= rob_cnt_t'(ROB_SIZE);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized
// in-order retirement run checked against a sequence-number based model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    reorder_buffer_if bus();

    reorder_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        rob_idx_t    idx;
        logic [31:0] value;
    } commit_ev_t;

    commit_ev_t  mon_commits[$];
    rob_idx_t    mon_stores[$];
    logic [31:0] mon_flushes[$];

    always @(negedge clk) begin
        if (rst_n && rdy) begin
            if (bus.commit_valid) mon_commits.push_back('{rd: bus.commit_rd, idx: bus.commit_index, value: bus.commit_value});
            if (bus.store_commit) mon_stores.push_back(bus.store_index);
            if (bus.flush)        mon_flushes.push_back(bus.flush_pc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = '0;
        bus.issue_jumped = 1'b0;
        bus.issue_opcode = OP_NOP;
        bus.issue_pc     = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_index    = '0;
        bus.cdb_value    = '0;
        bus.cdb_taken    = 1'b0;
        bus.cdb_target   = '0;
        bus.check1       = '0;
        bus.check2       = '0;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input opcode_t op, input logic jmp, input logic [31:0] pc);
        bus.issue_valid  = 1'b1;
        bus.issue_rd     = rd;
        bus.issue_opcode = op;
        bus.issue_jumped = jmp;
        bus.issue_pc     = pc;
    endtask

    task automatic drive_cdb(input rob_idx_t idx, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
        bus.cdb_valid  = 1'b1;
        bus.cdb_index  = idx;
        bus.cdb_value  = val;
        bus.cdb_taken  = tk;
        bus.cdb_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.commit_valid, bus.store_commit, bus.flush, bus.full} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got %b want 0000", {bus.commit_valid, bus.store_commit, bus.flush, bus.full});
        end
        for (int i = 0; i < 5; i++) begin
            drive_issue(5'(i + 1), OP_ADD, 1'b0, 32'(i * 4));
            tick();
        end
        idle();
        drive_cdb(6'd0, 32'h55, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        checks++;
        if ({bus.commit_valid, bus.commit_value} !== {1'b1, 32'h55}) begin
            errors++;
            $display("FAIL pre_reset_commit got %b/%h want 1/00000055", bus.commit_valid, bus.commit_value);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value, bus.store_commit, bus.store_index,
             bus.flush, bus.flush_pc, bus.full, bus.value_valid1, bus.value1, bus.value_valid2, bus.value2} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got cv=%b rd=%h idx=%h val=%h sc=%b fl=%b fpc=%h full=%b vv1=%b vv2=%b want all 0",
                     bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value, bus.store_commit,
                     bus.flush, bus.flush_pc, bus.full, bus.value_valid1, bus.value_valid2);
        end
    endtask

    task automatic test_in_order_commit();
        logic [43:0] exp_ev [3];
        exp_ev[0] = {1'b1, 5'd5, 6'd0, 32'h10};
        exp_ev[1] = {1'b1, 5'd6, 6'd1, 32'h11};
        exp_ev[2] = {1'b1, 5'd7, 6'd2, 32'h12};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_issue(5'(5 + i), OP_ADD, 1'b0, 32'(32'h1000 + i * 4));
            tick();
        end
        idle(); drive_cdb(6'd1, 32'h11, 1'b0, 32'h0); tick();
        idle(); drive_cdb(6'd0, 32'h10, 1'b0, 32'h0); tick();
        checks++;
        if (bus.commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_cdb_commit_bypass got commit_valid=%b want 0", bus.commit_valid);
        end
        idle(); drive_cdb(6'd2, 32'h12, 1'b0, 32'h0); tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value} !== exp_ev[i]) begin
                errors++;
                $display("FAIL in_order_commit_%0d got %h want %h", i,
                         {bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value}, exp_ev[i]);
            end
            tick();
        end
        checks++;
        if (bus.commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL commit_idle got commit_valid=%b want 0", bus.commit_valid);
        end
    endtask

    task automatic test_lookup_bypass();
        drive_issue(5'd8, OP_ADD, 1'b0, 32'h100C);
        tick();
        idle();
        bus.check1 = 6'd3;
        bus.check2 = 6'd2;
        #1;
        checks++;
        if ({bus.value_valid1, bus.value1, bus.value_valid2, bus.value2} !== {1'b0, 32'h0, 1'b1, 32'h12}) begin
            errors++;
            $display("FAIL lookup_before_cdb got %b/%h %b/%h want 0/00000000 1/00000012",
                     bus.value_valid1, bus.value1, bus.value_valid2, bus.value2);
        end
        drive_cdb(6'd3, 32'hABCD, 1'b0, 32'h0);
        #1;
        checks++;
        if ({bus.value_valid1, bus.value1} !== {1'b1, 32'hABCD}) begin
            errors++;
            $display("FAIL lookup_cdb_bypass got %b/%h want 1/0000abcd", bus.value_valid1, bus.value1);
        end
        tick();
        idle();
        bus.check1 = 6'd3;
        #1;
        checks++;
        if ({bus.value_valid1, bus.value1} !== {1'b1, 32'hABCD}) begin
            errors++;
            $display("FAIL lookup_stored got %b/%h want 1/0000abcd", bus.value_valid1, bus.value1);
        end
        tick(); tick();
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive_issue(5'd0, OP_BEQ, 1'b0, 32'h100); tick();
        drive_issue(5'd9, OP_ADD, 1'b0, 32'h104); tick();
        idle(); drive_cdb(6'd1, 32'h99, 1'b0, 32'h0); tick();
        idle(); drive_cdb(6'd0, 32'h0, 1'b1, 32'h200); tick();
        idle(); tick();
        checks++;
        if ({bus.flush, bus.flush_pc, bus.commit_valid} !== {1'b1, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL branch_mispredict got flush=%b pc=%h cv=%b want 1/00000200/0", bus.flush, bus.flush_pc, bus.commit_valid);
        end
        drive_issue(5'd10, OP_ADD, 1'b0, 32'h500);
        tick();
        idle();
        bus.check1 = 6'd1;
        #1;
        checks++;
        if ({bus.flush, bus.commit_valid, bus.value_valid1} !== 3'b000) begin
            errors++;
            $display("FAIL after_flush got flush=%b cv=%b vv1=%b want 000", bus.flush, bus.commit_valid, bus.value_valid1);
        end
        drive_issue(5'd11, OP_ADD, 1'b0, 32'h200); tick();
        idle(); drive_cdb(6'd0, 32'h77, 1'b0, 32'h0); tick();
        idle(); tick();
        checks++;
        if ({bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value} !== {1'b1, 5'd11, 6'd0, 32'h77}) begin
            errors++;
            $display("FAIL tag_realign got %b/%0d/%0d/%h want 1/11/0/00000077",
                     bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value);
        end
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        drive_issue(5'd0, OP_BNE, 1'b1, 32'h300); tick();
        idle(); drive_cdb(6'd0, 32'h0, 1'b0, 32'h999); tick();
        idle(); tick();
        checks++;
        if ({bus.flush, bus.flush_pc} !== {1'b1, 32'h304}) begin
            errors++;
            $display("FAIL branch_fallthrough got %b/%h want 1/00000304", bus.flush, bus.flush_pc);
        end
        tick();
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_one_cycle got %b want 0", bus.flush);
        end
    endtask

    task automatic test_jalr_and_rdy();
        do_reset();
        drive_issue(5'd1, OP_JALR, 1'b0, 32'h40); tick();
        idle(); drive_cdb(6'd0, 32'h44, 1'b0, 32'h80); tick();
        idle(); tick();
        checks++;
        if ({bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value, bus.flush, bus.flush_pc} !==
            {1'b1, 5'd1, 6'd0, 32'h44, 1'b1, 32'h80}) begin
            errors++;
            $display("FAIL jalr_commit got cv=%b rd=%0d idx=%0d val=%h flush=%b pc=%h want 1/1/0/00000044/1/00000080",
                     bus.commit_valid, bus.commit_rd, bus.commit_index, bus.commit_value, bus.flush, bus.flush_pc);
        end
        rdy = 1'b0;
        tick();
        checks++;
        if ({bus.commit_valid, bus.flush} !== 2'b11) begin
            errors++;
            $display("FAIL rdy_hold got cv/flush=%b want 11", {bus.commit_valid, bus.flush});
        end
        rdy = 1'b1;
        tick();
        checks++;
        if ({bus.commit_valid, bus.flush} !== 2'b00) begin
            errors++;
            $display("FAIL rdy_resume got cv/flush=%b want 00", {bus.commit_valid, bus.flush});
        end
    endtask

    task automatic test_fill_wrap();
        int wait_cycles;
        do_reset();
        checks++;
        if (bus.full !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty got full=%b want 0", bus.full);
        end
        for (int i = 0; i < ROB_SIZE; i++) begin
            drive_issue(5'(i % 31 + 1), OP_ADD, 1'b0, 32'(i * 4));
            tick();
            checks++;
            if (bus.full !== ((i + 1 + FULL_MARGIN) >= ROB_SIZE)) begin
                errors++;
                $display("FAIL fill_full count=%0d got %b want %b", i + 1, bus.full, (i + 1 + FULL_MARGIN) >= ROB_SIZE);
            end
        end
        idle();
        mon_commits.delete();
        for (int t = 0; t < ROB_SIZE; t++) begin
            drive_cdb(rob_idx_t'(t), 32'(32'h1000 + t), 1'b0, 32'h0);
            tick();
        end
        idle();
        drive_issue(5'd20, OP_ADD, 1'b0, 32'h2000);
        tick();
        idle();
        drive_cdb(6'd0, 32'h1234, 1'b0, 32'h0);
        tick();
        idle();
        wait_cycles = 0;
        while (mon_commits.size() < ROB_SIZE + 1 && wait_cycles < 200) begin
            tick();
            wait_cycles++;
        end
        checks++;
        if (mon_commits.size() != ROB_SIZE + 1) begin
            errors++;
            $display("FAIL fill_drain_count got %0d want %0d", mon_commits.size(), ROB_SIZE + 1);
        end
        for (int k = 0; k < mon_commits.size() && k < ROB_SIZE + 1; k++) begin
            commit_ev_t exp_ev;
            exp_ev = (k < ROB_SIZE) ? '{rd: 5'(k % 31 + 1), idx: rob_idx_t'(k), value: 32'(32'h1000 + k)}
                                    : '{rd: 5'd20, idx: 6'd0, value: 32'h1234};
            checks++;
            if ({mon_commits[k].rd, mon_commits[k].idx, mon_commits[k].value} !== {exp_ev.rd, exp_ev.idx, exp_ev.value}) begin
                errors++;
                $display("FAIL fill_commit_%0d got rd=%0d idx=%0d val=%h want rd=%0d idx=%0d val=%h", k,
                         mon_commits[k].rd, mon_commits[k].idx, mon_commits[k].value, exp_ev.rd, exp_ev.idx, exp_ev.value);
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 200;
        int          kind   [N];
        logic [4:0]  rd_s   [N];
        logic        jmp_s  [N];
        logic [31:0] val_s  [N];
        logic        lk_ready [ROB_SIZE];
        logic [31:0] lk_val   [ROB_SIZE];
        int          pending[$];
        commit_ev_t  exp_c[$];
        rob_idx_t    exp_s[$];
        int issued = 0;
        int guard = 0;
        int wait_cycles;

        do_reset();
        mon_commits.delete();
        mon_stores.delete();
        mon_flushes.delete();
        for (int i = 0; i < ROB_SIZE; i++) begin
            lk_ready[i] = 1'b0;
            lk_val[i]   = '0;
        end

        while ((issued < N || pending.size() > 0) && guard < 5000) begin
            logic        do_issue, do_cdb, exp_v;
            int          seq;
            logic [31:0] cv, exp_d;
            rob_idx_t    chk [2];
            logic        got_v [2];
            logic [31:0] got_d [2];
            guard++;
            idle();
            seq = 0;
            cv = '0;
            do_issue = (issued < N) && !bus.full && ($urandom_range(0, 3) != 0);
            if (do_issue) begin
                int r;
                r = $urandom_range(0, 9);
                kind[issued]  = (r < 5) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
                rd_s[issued]  = 5'($urandom_range(0, 31));
                jmp_s[issued] = 1'($urandom_range(0, 1));
                case (kind[issued])
                    0:       drive_issue(rd_s[issued], OP_ADD, 1'b0, 32'(issued * 4));
                    1:       drive_issue(rd_s[issued], OP_SW,  1'b0, 32'(issued * 4));
                    2:       drive_issue(rd_s[issued], OP_JAL, 1'b1, 32'(issued * 4));
                    default: drive_issue(rd_s[issued], OP_BEQ, jmp_s[issued], 32'(issued * 4));
                endcase
            end
            do_cdb = (pending.size() > 0) && ($urandom_range(0, 2) != 0);
            if (do_cdb) begin
                int p;
                p = $urandom_range(0, pending.size() - 1);
                seq = pending[p];
                pending.delete(p);
                cv = $urandom;
                val_s[seq] = cv;
                // Branches resolve to their predicted direction so the run never flushes.
                drive_cdb(rob_idx_t'(seq % ROB_SIZE), cv, (kind[seq] == 3) ? jmp_s[seq] : 1'($urandom_range(0, 1)), $urandom);
            end
            bus.check1 = rob_idx_t'($urandom_range(0, ROB_SIZE - 1));
            bus.check2 = rob_idx_t'($urandom_range(0, ROB_SIZE - 1));
            #1;
            chk[0] = bus.check1; chk[1] = bus.check2;
            got_v[0] = bus.value_valid1; got_v[1] = bus.value_valid2;
            got_d[0] = bus.value1; got_d[1] = bus.value2;
            for (int c = 0; c < 2; c++) begin
                if (do_cdb && (seq % ROB_SIZE) == int'(chk[c])) begin
                    exp_v = 1'b1; exp_d = cv;
                end else begin
                    exp_v = lk_ready[chk[c]]; exp_d = lk_ready[chk[c]] ? lk_val[chk[c]] : 32'h0;
                end
                checks++;
                if ({got_v[c], got_d[c]} !== {exp_v, exp_d}) begin
                    errors++;
                    $display("FAIL rand_lookup%0d idx=%0d got %b/%h want %b/%h", c + 1, chk[c], got_v[c], got_d[c], exp_v, exp_d);
                end
            end
            tick();
            if (do_issue) begin
                lk_ready[issued % ROB_SIZE] = 1'b0;
                pending.push_back(issued);
                issued++;
            end
            if (do_cdb) begin
                lk_ready[seq % ROB_SIZE] = 1'b1;
                lk_val[seq % ROB_SIZE]   = cv;
            end
        end
        idle();

        for (int s = 0; s < issued; s++) begin
            if ((kind[s] == 0 || kind[s] == 2) && rd_s[s] != 5'd0)
                exp_c.push_back('{rd: rd_s[s], idx: rob_idx_t'(s % ROB_SIZE), value: val_s[s]});
            else if (kind[s] == 1)
                exp_s.push_back(rob_idx_t'(s % ROB_SIZE));
        end
        wait_cycles = 0;
        while ((mon_commits.size() < exp_c.size() || mon_stores.size() < exp_s.size()) && wait_cycles < 300) begin
            tick();
            wait_cycles++;
        end
        repeat (8) tick();

        checks++;
        if (mon_commits.size() != exp_c.size() || mon_stores.size() != exp_s.size() || mon_flushes.size() != 0) begin
            errors++;
            $display("FAIL rand_counts got commits=%0d stores=%0d flushes=%0d want %0d/%0d/0",
                     mon_commits.size(), mon_stores.size(), mon_flushes.size(), exp_c.size(), exp_s.size());
        end
        for (int k = 0; k < exp_c.size() && k < mon_commits.size(); k++) begin
            checks++;
            if ({mon_commits[k].rd, mon_commits[k].idx, mon_commits[k].value} !== {exp_c[k].rd, exp_c[k].idx, exp_c[k].value}) begin
                errors++;
                $display("FAIL rand_commit_%0d got rd=%0d idx=%0d val=%h want rd=%0d idx=%0d val=%h", k,
                         mon_commits[k].rd, mon_commits[k].idx, mon_commits[k].value, exp_c[k].rd, exp_c[k].idx, exp_c[k].value);
            end
        end
        for (int k = 0; k < exp_s.size() && k < mon_stores.size(); k++) begin
            checks++;
            if (mon_stores[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL rand_store_%0d got idx=%0d want %0d", k, mon_stores[k], exp_s[k]);
            end
        end
    endtask

    initial begin
        rdy   = 1'b1;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_in_order_commit();
        test_lookup_bypass();
        test_branch_flush();
        test_branch_not_taken();
        test_jalr_and_rdy();
        test_fill_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
